// File: rtl/vx_cluster_mem_arb_pkg.sv
// Shared helpers for the cluster memory arbiter.
//   up_clog2 : index width for a count of items, never less than one bit so
//              that a single-requester build still has a legal select field.
package vx_cluster_mem_arb_pkg;

  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_cluster_mem_arb_rr.sv
// Round-robin arbiter.
//   clk, reset    : clock, synchronous active-high reset
//   valids        : per-requester request lines
//   grant_ready   : downstream can take the granted request this cycle;
//                   the priority pointer only moves when this is high
//   grant_valid   : at least one requester is being granted
//   grant_index   : binary index of the granted requester
//   grant_onehot  : one-hot form of grant_index (all zero when no grant)
//   last_grant    : current priority pointer, exposed for observation
// The grant is purely combinational from the current valids, so a requester
// that drops its valid never blocks the others.
module vx_cluster_mem_arb_rr
  import vx_cluster_mem_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int SEL_WIDTH = up_clog2(NUM_REQS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  valids,
  input  logic                 grant_ready,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant_index,
  output logic [NUM_REQS-1:0]  grant_onehot,
  output logic [SEL_WIDTH-1:0] last_grant
);

  localparam logic [SEL_WIDTH:0] NUM_W = (SEL_WIDTH+1)'(NUM_REQS);

  logic [SEL_WIDTH:0]   cand_sum;
  logic [SEL_WIDTH-1:0] cand;

  // Scan starting one past the last winner; the sum is one bit wider than
  // the index so the wrap can be done with a single conditional subtract.
  always_comb begin
    grant_valid  = 1'b0;
    grant_index  = '0;
    grant_onehot = '0;
    cand_sum     = '0;
    cand         = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand_sum = {1'b0, last_grant} + (SEL_WIDTH+1)'(i + 1);
      if (cand_sum >= NUM_W) begin
        cand_sum = cand_sum - NUM_W;
      end
      cand = cand_sum[SEL_WIDTH-1:0];
      if (!grant_valid && valids[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
    if (grant_valid) begin
      grant_onehot[grant_index] = 1'b1;
    end
  end

  // Reset points at the last requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SEL_WIDTH'(NUM_REQS - 1);
    end else if (grant_valid && grant_ready) begin
      last_grant <= grant_index;
    end
  end

endmodule

// File: rtl/vx_cluster_mem_arb.sv
// Cluster memory arbiter: shares one memory port among NUM_REQS requesters
// and routes responses back by a requester index carried in the tag LSBs.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; a producer holds valid and payload
// stable until that edge, and ready may depend combinationally on valid.
//
// Ports
//   clk, reset                      : clock, synchronous active-high reset
//   in_req_valid/ready/rw           : per-requester request handshake, 1=write
//   in_req_addr/data/byteen/tag     : flattened per-requester request payload
//   in_rsp_valid/ready              : per-requester response handshake
//   in_rsp_data/tag                 : response payload, replicated per slot
//   out_req_valid/ready             : shared memory request handshake
//   out_req_rw/addr/data/byteen/tag : registered request, tag = {tag, sel}
//   out_rsp_valid/ready/data/tag    : shared memory response, sel in tag LSBs
module vx_cluster_mem_arb
  import vx_cluster_mem_arb_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_SIZE  = 64,
  parameter int TAG_WIDTH  = 8,
  localparam int SEL_WIDTH  = up_clog2(NUM_REQS),
  localparam int DATA_WIDTH = DATA_SIZE * 8,
  localparam int OTAG_WIDTH = TAG_WIDTH + SEL_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic [NUM_REQS-1:0]             in_req_valid,
  output logic [NUM_REQS-1:0]             in_req_ready,
  input  logic [NUM_REQS-1:0]             in_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]  in_req_data,
  input  logic [NUM_REQS*DATA_SIZE-1:0]   in_req_byteen,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   in_req_tag,

  output logic [NUM_REQS-1:0]             in_rsp_valid,
  input  logic [NUM_REQS-1:0]             in_rsp_ready,
  output logic [NUM_REQS*DATA_WIDTH-1:0]  in_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]   in_rsp_tag,

  output logic                            out_req_valid,
  input  logic                            out_req_ready,
  output logic                            out_req_rw,
  output logic [ADDR_WIDTH-1:0]           out_req_addr,
  output logic [DATA_WIDTH-1:0]           out_req_data,
  output logic [DATA_SIZE-1:0]            out_req_byteen,
  output logic [OTAG_WIDTH-1:0]           out_req_tag,

  input  logic                            out_rsp_valid,
  output logic                            out_rsp_ready,
  input  logic [DATA_WIDTH-1:0]           out_rsp_data,
  input  logic [OTAG_WIDTH-1:0]           out_rsp_tag
);

  localparam logic [SEL_WIDTH:0] NUM_W = (SEL_WIDTH+1)'(NUM_REQS);

  // ---------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] req_addr_a   [NUM_REQS];
  logic [DATA_WIDTH-1:0] req_data_a   [NUM_REQS];
  logic [DATA_SIZE-1:0]  req_byteen_a [NUM_REQS];
  logic [TAG_WIDTH-1:0]  req_tag_a    [NUM_REQS];

  logic                  req_en;
  logic                  grant_valid;
  logic [SEL_WIDTH-1:0]  grant_index;
  logic [NUM_REQS-1:0]   grant_onehot;
  logic [SEL_WIDTH-1:0]  last_grant;

  // The single request register can load whenever it is empty or draining.
  assign req_en       = !out_req_valid || out_req_ready;
  assign in_req_ready = grant_onehot & {NUM_REQS{req_en}};

  vx_cluster_mem_arb_rr #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .valids       (in_req_valid),
    .grant_ready  (req_en),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot),
    .last_grant   (last_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_req_valid <= 1'b0;
    end else if (req_en) begin
      out_req_valid <= grant_valid;
    end
    // Payload has no reset; it is only meaningful while out_req_valid.
    if (req_en && grant_valid) begin
      out_req_rw     <= in_req_rw[grant_index];
      out_req_addr   <= req_addr_a[grant_index];
      out_req_data   <= req_data_a[grant_index];
      out_req_byteen <= req_byteen_a[grant_index];
      out_req_tag    <= {req_tag_a[grant_index], grant_index};
    end
  end

  // ---------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic [TAG_WIDTH-1:0]  rsp_tag_r;
  logic [SEL_WIDTH-1:0]  sel_r;
  logic [SEL_WIDTH-1:0]  sel_in;
  logic                  sel_legal;

  assign sel_in        = out_rsp_tag[SEL_WIDTH-1:0];
  assign sel_legal     = ({1'b0, sel_in} < NUM_W);
  assign out_rsp_ready = !rsp_valid_r || in_rsp_ready[sel_r];

  // An out-of-range select is consumed but never becomes valid, so it can
  // not stall the shared response port waiting on a requester that is absent.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
    end else if (out_rsp_ready) begin
      rsp_valid_r <= out_rsp_valid && sel_legal;
    end
    if (out_rsp_ready && out_rsp_valid) begin
      rsp_data_r <= out_rsp_data;
      rsp_tag_r  <= out_rsp_tag[OTAG_WIDTH-1:SEL_WIDTH];
      sel_r      <= sel_in;
    end
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_port
    assign req_addr_a[i]   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data_a[i]   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign req_byteen_a[i] = in_req_byteen[i*DATA_SIZE +: DATA_SIZE];
    assign req_tag_a[i]    = in_req_tag[i*TAG_WIDTH +: TAG_WIDTH];

    assign in_rsp_valid[i]                       = rsp_valid_r && (sel_r == SEL_WIDTH'(i));
    assign in_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data_r;
    assign in_rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]    = rsp_tag_r;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && out_rsp_valid && out_rsp_ready) begin
      assert (sel_legal);
    end
  end
`endif

endmodule

// File: tb/tb_vx_cluster_mem_arb.sv
module tb_vx_cluster_mem_arb;

  localparam int N   = 4;
  localparam int AW  = 26;
  localparam int DS  = 64;
  localparam int DW  = DS * 8;
  localparam int TW  = 8;
  localparam int SW  = 2;
  localparam int OTW = TW + SW;
  localparam int EW  = SW + TW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    in_req_valid, in_req_ready, in_req_rw;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*DS-1:0] in_req_byteen;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [N*DW-1:0] in_rsp_data;
  logic [N*TW-1:0] in_rsp_tag;
  logic            out_req_valid, out_req_ready, out_req_rw;
  logic [AW-1:0]   out_req_addr;
  logic [DW-1:0]   out_req_data;
  logic [DS-1:0]   out_req_byteen;
  logic [OTW-1:0]  out_req_tag;
  logic            out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]   out_rsp_data;
  logic [OTW-1:0]  out_rsp_tag;

  vx_cluster_mem_arb #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_byteen(in_req_byteen),
    .in_req_tag(in_req_tag),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_byteen(out_req_byteen),
    .out_req_tag(out_req_tag),
    .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Request side: one slot plus a "most recent winner" pointer.
  bit             m_req_v;
  logic           m_rw;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;
  logic [DS-1:0]  m_be;
  logic [OTW-1:0] m_tag;
  int             m_last;
  // Response side: one slot addressed to requester m_sel.
  bit             m_rsp_v;
  int             m_sel;
  logic [DW-1:0]  m_rdata;
  logic [TW-1:0]  m_rtag;

  // Scoreboard: reads in acceptance order {requester, tag, data}.
  logic [EW-1:0]     exp_q[$];
  // Emulated memory: pending read responses {out tag, data}.
  logic [OTW+DW-1:0] mem_q[$];
  int wr_in, wr_out, rd_done;

  function automatic int mdl_grant();
    for (int k = 0; k < N; k++) begin
      if (in_req_valid[(m_last + 1 + k) % N]) return (m_last + 1 + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_req_ready();
    int g;
    g = mdl_grant();
    if ((!m_req_v || out_req_ready) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  function automatic logic exp_rsp_ready();
    return !m_rsp_v || in_rsp_ready[m_sel];
  endfunction

  function automatic logic [N-1:0] exp_rsp_valid();
    return m_rsp_v ? (N'(1) << m_sel) : '0;
  endfunction

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {16{32'(a) ^ 32'hC0DE_1234}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_payloads();
    for (int i = 0; i < N; i++) begin
      in_req_rw[i]           = 1'($urandom);
      in_req_addr[i*AW +: AW] = AW'($urandom);
      in_req_data[i*DW +: DW] = {16{$urandom}};
      in_req_byteen[i*DS +: DS] = {$urandom, $urandom};
      in_req_tag[i*TW +: TW]  = TW'($urandom);
    end
  endtask

  // Advance one clock; the model takes the inputs that were present before
  // the edge. Returns at posedge+1 so new inputs can be driven.
  task automatic step();
    bit en, ren;
    int g;
    en  = !m_req_v || out_req_ready;
    ren = exp_rsp_ready();
    g   = mdl_grant();
    @(posedge clk);
    if (reset) begin
      m_req_v = 0;
      m_rsp_v = 0;
      m_last  = N - 1;
    end else begin
      if (en) begin
        m_req_v = (g >= 0);
        if (g >= 0) begin
          m_rw   = in_req_rw[g];
          m_addr = in_req_addr[g*AW +: AW];
          m_data = in_req_data[g*DW +: DW];
          m_be   = in_req_byteen[g*DS +: DS];
          m_tag  = {in_req_tag[g*TW +: TW], SW'(g)};
          m_last = g;
        end
      end
      if (ren) begin
        m_rsp_v = out_rsp_valid;
        if (out_rsp_valid) begin
          m_sel   = int'(out_rsp_tag[SW-1:0]);
          m_rdata = out_rsp_data;
          m_rtag  = out_rsp_tag[OTW-1:SW];
        end
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_req_valid = '0; in_req_rw = '0; in_req_addr = '0; in_req_data = '0;
    in_req_byteen = '0; in_req_tag = '0; in_rsp_ready = '1;
    out_req_ready = 1'b1; out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (out_req_valid !== 1'b0) begin errors++; $display("FAIL rst_out_req_valid: got %b want 0", out_req_valid); end
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_in_rsp_valid: got %b want 0000", in_rsp_valid); end
    checks++; if (out_rsp_ready !== 1'b1) begin errors++; $display("FAIL rst_out_rsp_ready: got %b want 1", out_rsp_ready); end
    in_req_valid = '1;
    #1;
    checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_priority: got %b want 0001", in_req_ready); end
    in_req_valid = '0;
    #1;
  endtask

  task automatic test_single();
    rand_payloads();
    in_req_valid = 4'b0001;
    in_req_rw[0] = 1'b0;
    in_req_addr[0 +: AW] = AW'(32'h100);
    in_req_tag[0 +: TW] = 8'h5A;
    #1;
    checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", in_req_ready); end
    step();
    in_req_valid = '0;
    #1;
    checks++; if (out_req_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_req_valid); end
    checks++; if (out_req_addr !== AW'(32'h100)) begin errors++; $display("FAIL single_addr: got %h want 100", out_req_addr); end
    checks++; if (out_req_tag !== 10'h168) begin errors++; $display("FAIL single_tag: got %h want 168", out_req_tag); end
    checks++; if (out_req_data !== m_data) begin errors++; $display("FAIL single_data: got %h want %h", out_req_data[31:0], m_data[31:0]); end
    step();
  endtask

  task automatic test_fairness();
    int first;
    first = (m_last + 1) % N;
    in_req_valid = '1;
    out_req_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rand_payloads();
      #1;
      checks++; if (in_req_ready !== exp_req_ready()) begin errors++; $display("FAIL fair_ready c=%0d: got %b want %b", c, in_req_ready, exp_req_ready()); end
      if (c > 0) begin
        checks++; if (out_req_tag[SW-1:0] !== SW'((first + c - 1) % N)) begin errors++; $display("FAIL fair_order c=%0d: got %0d want %0d", c, out_req_tag[SW-1:0], (first + c - 1) % N); end
        checks++; if (out_req_valid !== 1'b1 || out_req_tag !== m_tag || out_req_addr !== m_addr || out_req_byteen !== m_be) begin errors++; $display("FAIL fair_payload c=%0d: got tag %h addr %h want tag %h addr %h", c, out_req_tag, out_req_addr, m_tag, m_addr); end
      end
      step();
    end
    in_req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    out_req_ready = 1'b0;
    rand_payloads();
    in_req_valid = 4'b0100;
    #1;
    checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL bp_load: got %b want 0100", in_req_ready); end
    hold_addr = in_req_addr[2*AW +: AW];
    hold_data = in_req_data[2*DW +: DW];
    step();
    in_req_valid = 4'b1100;
    for (int c = 0; c < 5; c++) begin
      rand_payloads();
      #1;
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d: got %b want 0000", c, in_req_ready); end
      checks++; if (out_req_valid !== 1'b1 || out_req_addr !== hold_addr || out_req_data !== hold_data || out_req_tag[SW-1:0] !== 2'd2) begin errors++; $display("FAIL bp_hold c=%0d: got v=%b addr %h sel %0d want v=1 addr %h sel 2", c, out_req_valid, out_req_addr, out_req_tag[SW-1:0], hold_addr); end
      step();
    end
    out_req_ready = 1'b1;
    #1;
    checks++; if (in_req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release: got %b want 1000", in_req_ready); end
    step();
    in_req_valid = '0;
    #1;
    checks++; if (out_req_valid !== 1'b1 || out_req_tag[SW-1:0] !== 2'd3) begin errors++; $display("FAIL bp_next: got v=%b sel %0d want v=1 sel 3", out_req_valid, out_req_tag[SW-1:0]); end
    step();
  endtask

  task automatic test_rsp_routing();
    in_rsp_ready  = '0;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h33, 2'd3};
    out_rsp_data  = DW'(32'hDEAD);
    #1;
    checks++; if (out_rsp_ready !== 1'b1) begin errors++; $display("FAIL rsp_empty_ready: got %b want 1", out_rsp_ready); end
    step();
    out_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_rsp_valid !== 4'b1000) begin errors++; $display("FAIL rsp_valid c=%0d: got %b want 1000", c, in_rsp_valid); end
      checks++; if (in_rsp_tag[3*TW +: TW] !== 8'h33 || in_rsp_data[3*DW +: DW] !== DW'(32'hDEAD)) begin errors++; $display("FAIL rsp_payload c=%0d: got tag %h data %h want 33 dead", c, in_rsp_tag[3*TW +: TW], in_rsp_data[3*DW +: 32]); end
      checks++; if (out_rsp_ready !== 1'b0) begin errors++; $display("FAIL rsp_stall c=%0d: got %b want 0", c, out_rsp_ready); end
      step();
    end
    in_rsp_ready = 4'b1000;
    #1;
    checks++; if (out_rsp_ready !== 1'b1) begin errors++; $display("FAIL rsp_release: got %b want 1", out_rsp_ready); end
    step();
    #1;
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rsp_drained: got %b want 0000", in_rsp_valid); end
  endtask

  task automatic test_mixed();
    bit rsp_hs;
    logic [N-1:0] rdy;
    logic [SW-1:0] es;
    logic [TW-1:0] et;
    logic [DW-1:0] ed;
    wr_in = 0; wr_out = 0; rd_done = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 400) begin
        in_req_valid  = N'($urandom);
        rand_payloads();
        out_req_ready = ($urandom_range(0, 3) != 0);
        in_rsp_ready  = N'($urandom);
      end else begin
        in_req_valid  = '0;
        out_req_ready = 1'b1;
        in_rsp_ready  = '1;
      end
      if (!out_rsp_valid && mem_q.size() > 0 && (c >= 400 || $urandom_range(0, 1) == 1)) begin
        out_rsp_valid = 1'b1;
        {out_rsp_tag, out_rsp_data} = mem_q[0];
      end
      #1;
      checks++; if (in_req_ready !== exp_req_ready()) begin errors++; $display("FAIL mix_req_ready c=%0d: got %b want %b", c, in_req_ready, exp_req_ready()); end
      checks++; if (out_rsp_ready !== exp_rsp_ready()) begin errors++; $display("FAIL mix_rsp_ready c=%0d: got %b want %b", c, out_rsp_ready, exp_rsp_ready()); end
      checks++; if (in_rsp_valid !== exp_rsp_valid()) begin errors++; $display("FAIL mix_rsp_valid c=%0d: got %b want %b", c, in_rsp_valid, exp_rsp_valid()); end
      checks++; if (out_req_valid !== m_req_v || (m_req_v && (out_req_tag !== m_tag || out_req_addr !== m_addr || out_req_rw !== m_rw || out_req_data !== m_data))) begin errors++; $display("FAIL mix_out_req c=%0d: got v=%b tag %h addr %h want v=%b tag %h addr %h", c, out_req_valid, out_req_tag, out_req_addr, m_req_v, m_tag, m_addr); end
      // requester side acceptance
      rdy = exp_req_ready();
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && in_req_valid[i]) begin
          if (in_req_rw[i]) wr_in++;
          else exp_q.push_back({SW'(i), in_req_tag[i*TW +: TW], mem_data(in_req_addr[i*AW +: AW])});
        end
      end
      // memory side acceptance
      if (m_req_v && out_req_ready) begin
        if (out_req_rw) wr_out++;
        else mem_q.push_back({out_req_tag, mem_data(out_req_addr)});
      end
      rsp_hs = out_rsp_valid && exp_rsp_ready();
      // delivered responses
      for (int i = 0; i < N; i++) begin
        if (in_rsp_valid[i] && in_rsp_ready[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL mix_sb_extra c=%0d: response on %0d with none expected", c, i);
          end else begin
            {es, et, ed} = exp_q.pop_front();
            rd_done++;
            if (SW'(i) !== es || in_rsp_tag[i*TW +: TW] !== et || in_rsp_data[i*DW +: DW] !== ed) begin
              errors++; $display("FAIL mix_sb c=%0d: got req %0d tag %h data %h want req %0d tag %h data %h", c, i, in_rsp_tag[i*TW +: TW], in_rsp_data[i*DW +: 32], es, et, ed[31:0]);
            end
          end
        end
      end
      step();
      if (rsp_hs) begin
        void'(mem_q.pop_front());
        out_rsp_valid = 1'b0;
      end
    end
    checks++; if (exp_q.size() != 0 || mem_q.size() != 0) begin errors++; $display("FAIL mix_drain: got %0d/%0d pending want 0/0", exp_q.size(), mem_q.size()); end
    checks++; if (wr_in != wr_out) begin errors++; $display("FAIL mix_writes: got %0d out want %0d", wr_out, wr_in); end
    checks++; if (rd_done == 0 || wr_in == 0) begin errors++; $display("FAIL mix_activity: got reads %0d writes %0d want both nonzero", rd_done, wr_in); end
  endtask

  task automatic test_reset_mid();
    rand_payloads();
    in_req_valid  = 4'b0010;
    out_req_ready = 1'b0;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h11, 2'd1};
    out_rsp_data  = DW'(32'hBEEF);
    in_rsp_ready  = '0;
    step();
    in_req_valid  = '0;
    out_rsp_valid = 1'b0;
    #1;
    checks++; if (out_req_valid !== 1'b1 || in_rsp_valid !== 4'b0010) begin errors++; $display("FAIL mid_loaded: got %b/%b want 1/0010", out_req_valid, in_rsp_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_req_valid = '1;
    #1;
    checks++; if (out_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_cleared: got %b want 0", out_req_valid); end
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_cleared: got %b want 0000", in_rsp_valid); end
    checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL mid_priority: got %b want 0001", in_req_ready); end
    in_req_valid = '0;
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_req_v = 0; m_rsp_v = 0; m_last = N - 1; m_sel = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_rsp_routing();
    test_mixed();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
